// File: rtl/spmv_job_controller.sv
// spmv_job_controller: doorbell poller and job sequencer for the SpMV engine, owning SRAM A/B outside jobs.
// Optional per-job watchdog enabled by defining SPMV_JOB_TIMEOUT_EN.
module spmv_job_controller #(
  parameter int AW            = 5,
  parameter int DW            = 256,
  parameter int DOORBELL_ADDR = 0,
  parameter int POLL_INTERVAL = 4,
  parameter int TIMEOUT_CYC   = 65535
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [DW-1:0] i_rd_data_a,
  output logic [AW-1:0] o_addr_a,
  output logic          o_wr_en_a,
  output logic [DW-1:0] o_wr_data_a,
  output logic [AW-1:0] o_addr_b,
  output logic          o_wr_en_b,
  output logic [DW-1:0] o_wr_data_b,
  input  logic [AW-1:0] i_eng_addr_a,
  input  logic [AW-1:0] i_eng_addr_b,
  input  logic          i_eng_wr_en_a,
  input  logic          i_eng_wr_en_b,
  input  logic [DW-1:0] i_eng_wr_data_b,
  output logic          o_eng_start,
  output logic [7:0]    o_eng_job,
  input  logic          i_eng_done,
  output logic [2:0]    o_state,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err
);
  typedef enum logic [2:0] {IDLE, POLL, START, OPS, WB, DONE} state_t;
  localparam int IW = $clog2(POLL_INTERVAL + 1);
  state_t        state;
  logic [IW-1:0] icnt;
  logic [7:0]    n, job;
  logic [31:0]   cyc;
  logic          err, tmo, last, ops;
  logic [DW-1:0] status;
  logic          unused_rd;
  assign unused_rd = ^{i_rd_data_a[DW-1:16], i_rd_data_a[7:1]};
  // a job count of zero still runs a single job
  assign last = (n == 8'd0) || (job == n - 8'd1);
`ifdef SPMV_JOB_TIMEOUT_EN
  logic [31:0] wd;
  assign tmo = wd == 32'(TIMEOUT_CYC - 1);
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) wd <= '0;
    else if (state == START) wd <= '0;
    else if (state == OPS) wd <= wd + 32'd1;
`else
  assign tmo = 1'b0;
`endif
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      icnt  <= '0;
      n     <= '0;
      job   <= '0;
      cyc   <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          icnt  <= (icnt == IW'(POLL_INTERVAL - 1)) ? '0 : icnt + 1'b1;
          state <= (icnt == IW'(POLL_INTERVAL - 1)) ? POLL : IDLE;
        end
        POLL: begin
          if (i_rd_data_a[0]) begin
            n     <= i_rd_data_a[15:8];
            err   <= 1'b0;
            cyc   <= '0;
            job   <= '0;
            state <= START;
          end else state <= IDLE;
        end
        START: state <= OPS;
        OPS: begin
          cyc <= (&cyc) ? cyc : cyc + 32'd1;
          if (i_eng_done) begin
            job   <= last ? job : job + 8'd1;
            state <= last ? WB : START;
          end else if (tmo) begin
            err   <= 1'b1;
            state <= WB;
          end
        end
        WB:      state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end
  always_comb begin
    status        = '0;
    status[63:32] = cyc;
    status[15:8]  = n;
    status[1]     = err;
  end
  assign ops         = state == OPS;
  assign o_addr_a    = ops ? i_eng_addr_a : AW'(DOORBELL_ADDR);
  assign o_wr_en_a   = ops ? i_eng_wr_en_a : state == WB;
  assign o_wr_data_a = (state == WB) ? status : '0;
  assign o_addr_b    = ops ? i_eng_addr_b : '0;
  assign o_wr_en_b   = ops & i_eng_wr_en_b;
  assign o_wr_data_b = ops ? i_eng_wr_data_b : '0;
  assign o_eng_start = state == START;
  assign o_eng_job   = job;
  assign o_state     = state;
  assign o_busy      = (state != IDLE) && (state != POLL);
  assign o_done      = state == DONE;
  assign o_err       = err;
endmodule

// File: tb/tb_spmv_job_controller.sv
// tb_spmv_job_controller: directed stimulus with a scoreboard of expected engine starts and status write-backs.
module tb_spmv_job_controller;
  localparam int AW = 5;
  localparam int DW = 256;
`ifdef SPMV_JOB_TIMEOUT_EN
  localparam int TO = 20;
`else
  localparam int TO = 65535;
`endif
  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic [DW-1:0] i_rd_data_a = '0;
  logic [AW-1:0] o_addr_a, o_addr_b, i_eng_addr_a, i_eng_addr_b;
  logic          o_wr_en_a, o_wr_en_b, i_eng_wr_en_a, i_eng_wr_en_b;
  logic [DW-1:0] o_wr_data_a, o_wr_data_b, i_eng_wr_data_b;
  logic          o_eng_start, i_eng_done, o_busy, o_done, o_err;
  logic [7:0]    o_eng_job;
  logic [2:0]    o_state;

  spmv_job_controller #(.AW(AW), .DW(DW), .DOORBELL_ADDR(0), .POLL_INTERVAL(4), .TIMEOUT_CYC(TO)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_rd_data_a(i_rd_data_a),
    .o_addr_a(o_addr_a), .o_wr_en_a(o_wr_en_a), .o_wr_data_a(o_wr_data_a),
    .o_addr_b(o_addr_b), .o_wr_en_b(o_wr_en_b), .o_wr_data_b(o_wr_data_b),
    .i_eng_addr_a(i_eng_addr_a), .i_eng_addr_b(i_eng_addr_b),
    .i_eng_wr_en_a(i_eng_wr_en_a), .i_eng_wr_en_b(i_eng_wr_en_b),
    .i_eng_wr_data_b(i_eng_wr_data_b), .o_eng_start(o_eng_start), .o_eng_job(o_eng_job),
    .i_eng_done(i_eng_done), .o_state(o_state), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  // doorbell word of SRAM A; other addresses read as zero
  logic [DW-1:0] db = '0;
  logic [DW-1:0] db_val = '0;
  logic          db_req = 1'b0;
  always @(posedge i_clk) begin
    i_rd_data_a <= (o_addr_a == '0) ? db : '0;
    if (db_req) db <= db_val;
    else if (o_wr_en_a && o_addr_a == '0) db <= o_wr_data_a;
  end

  // engine model: done on the done_lat-th OPS cycle after each start; 0 means never
  int done_lat = 11;
  int k = 0;
  always @(negedge i_clk) begin
    if (i_rst) begin
      k = 0;
      i_eng_done = 1'b0;
    end else begin
      if (o_eng_start) k = 0;
      if (o_state == 3'd3) k++;
      i_eng_done = (done_lat != 0) && (o_state == 3'd3) && (k == done_lat);
    end
  end

  int tests = 0, fails = 0;
  int done_cnt = 0, start_cnt = 0, poll_cnt = 0;
  logic [63:0] exp_q[$];
  logic [7:0]  job_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] stat(input logic [7:0] n, input logic [31:0] c, input logic e);
    return {c, 16'd0, n, 6'd0, e, 1'b0};
  endfunction

  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_state == 3'd1) poll_cnt++;
      if (o_done) done_cnt++;
      if (o_eng_start) begin
        start_cnt++;
        if (job_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_start: job %0d with nothing expected", o_eng_job);
        end else chk("eng_job", 64'(o_eng_job), 64'(job_q.pop_front()));
      end
      if (o_state == 3'd4) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_wb: status %h with nothing expected", o_wr_data_a[63:0]);
        end else begin
          chk("wb_addr", 64'(o_addr_a), 64'd0);
          chk("wb_we", 64'(o_wr_en_a), 64'd1);
          chk("status_lo", o_wr_data_a[63:0], exp_q.pop_front());
          chk("status_hi_zero", 64'(o_wr_data_a[DW-1:64] == '0), 64'd1);
        end
      end
    end
  end

  task automatic ring(input logic [15:0] v);
    @(negedge i_clk);
    db_val = DW'(v);
    db_req = 1'b1;
    @(negedge i_clk);
    db_req = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0 = done_cnt;
    int i = 0;
    while (done_cnt == d0 && i < budget) begin
      @(negedge i_clk);
      i++;
    end
    chk(name, 64'(done_cnt - d0), 64'd1);
  endtask

  task automatic wait_state(input string name, input logic [2:0] s, input logic [7:0] j, input int budget);
    int i = 0;
    while (!(o_state == s && o_eng_job == j) && i < budget) begin
      @(negedge i_clk);
      i++;
    end
    chk(name, 64'(o_state == s && o_eng_job == j), 64'd1);
  endtask

  initial begin
    int s0;
    i_eng_addr_a = '0; i_eng_addr_b = '0; i_eng_wr_en_a = 1'b0; i_eng_wr_en_b = 1'b0;
    i_eng_wr_data_b = '0;
    repeat (3) @(negedge i_clk);
    chk("rst_state", 64'(o_state), 64'd0);
    chk("rst_ctl", 64'({o_busy, o_done, o_err, o_eng_start, o_wr_en_a, o_wr_en_b}), 64'd0);
    chk("rst_job", 64'(o_eng_job), 64'd0);
    // idle polling with engine inputs active must keep SRAM B quiet
    i_eng_addr_a = 5'd9; i_eng_addr_b = 5'd7; i_eng_wr_en_a = 1'b1; i_eng_wr_en_b = 1'b1;
    i_eng_wr_data_b = DW'(16'hABCD);
    poll_cnt = 0;
    i_rst = 1'b0;
    repeat (50) @(negedge i_clk);
    chk("poll_count_50", 64'(poll_cnt), 64'd10);
    chk("no_start_idle", 64'(start_cnt), 64'd0);
    chk("idle_b_zero", 64'({o_addr_b, o_wr_en_b, o_wr_data_b[15:0]}), 64'd0);
    chk("idle_addr_a", 64'({o_addr_a, o_wr_en_a}), 64'd0);
    // three jobs, 11 OPS cycles each
    job_q = '{8'd0, 8'd1, 8'd2};
    exp_q.push_back(stat(8'd3, 32'd33, 1'b0));
    ring(16'h0301);
    wait_state("reach_ops_job0", 3'd3, 8'd0, 20);
    chk("ops_b_addr", 64'(o_addr_b), 64'd7);
    chk("ops_b_we", 64'(o_wr_en_b), 64'd1);
    chk("ops_b_data", o_wr_data_b[63:0], 64'hABCD);
    chk("ops_a_mux", 64'({o_addr_a, o_wr_en_a}), 64'({5'd9, 1'b1}));
    chk("ops_a_data", o_wr_data_a[63:0], 64'd0);
    chk("ops_busy", 64'(o_busy), 64'd1);
    wait_done("done_n3", 200);
    chk("starts_n3", 64'(start_cnt), 64'd3);
    chk("job_q_empty_n3", 64'(job_q.size()), 64'd0);
    chk("db_after_n3", db[63:0], stat(8'd3, 32'd33, 1'b0));
    // N=0 runs one job
    s0 = start_cnt;
    job_q.push_back(8'd0);
    exp_q.push_back(stat(8'd0, 32'd11, 1'b0));
    ring(16'h0001);
    wait_done("done_n0", 100);
    chk("starts_n0", 64'(start_cnt - s0), 64'd1);
    // reset during the second job of four
    job_q = '{8'd0, 8'd1};
    ring(16'h0401);
    wait_state("reach_ops_job1", 3'd3, 8'd1, 100);
    #2 i_rst = 1'b1;
    #1;
    chk("midrst_ctl", 64'({o_state, o_busy, o_done, o_err, o_eng_start, o_wr_en_a, o_wr_en_b}), 64'd0);
    chk("midrst_job", 64'(o_eng_job), 64'd0);
    chk("midrst_addr", 64'({o_addr_a, o_addr_b}), 64'd0);
    chk("midrst_data", 64'({o_wr_data_a != '0, o_wr_data_b != '0}), 64'd0);
    db_val = '0;
    db_req = 1'b1;
    @(negedge i_clk);
    db_req = 1'b0;
    chk("job_q_empty_rst", 64'(job_q.size()), 64'd0);
    i_rst = 1'b0;
    s0 = start_cnt;
    @(negedge i_clk);
    chk("post_rst_idle", 64'(o_state), 64'd0);
    wait_state("poll_resumes", 3'd1, 8'd0, 10);
    repeat (12) @(negedge i_clk);
    chk("no_start_after_rst", 64'(start_cnt - s0), 64'd0);
`ifdef SPMV_JOB_TIMEOUT_EN
    done_lat = 0;
    job_q.push_back(8'd0);
    exp_q.push_back(stat(8'd2, 32'd20, 1'b1));
    ring(16'h0201);
    wait_done("done_timeout", 100);
    chk("err_set", 64'(o_err), 64'd1);
    repeat (10) @(negedge i_clk);
    chk("err_sticky", 64'(o_err), 64'd1);
    done_lat = 11;
    job_q.push_back(8'd0);
    exp_q.push_back(stat(8'd1, 32'd11, 1'b0));
    ring(16'h0101);
    wait_state("reach_start_clear", 3'd2, 8'd0, 20);
    chk("err_cleared", 64'(o_err), 64'd0);
    wait_done("done_after_err", 100);
`else
    chk("err_never", 64'(o_err), 64'd0);
`endif
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
